// File: rtl/cmd_issue_ctrl.sv
// SD CMD-line issue controller: arbitrates host and auto-CMD12 requests, launches the
// CMD transmitter, supervises the response window and enforces the idle gap between commands.
module cmd_issue_ctrl #(
   parameter int NccCycles  = 8,
   parameter int RspTimeout = 64
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clk_en_i,
   input  logic        host_req_i,
   input  logic [5:0]  host_cmd_nr_i,
   input  logic [31:0] host_arg_i,
   input  logic [1:0]  host_rsp_type_i,
   input  logic        auto_req_i,
   output logic        host_ack_o,
   output logic        auto_ack_o,
   output logic        start_tx_o,
   output logic [5:0]  cmd_nr_o,
   output logic [31:0] cmd_argument_o,
   input  logic        tx_done_i,
   input  logic        rsp_start_i,
   input  logic        rsp_done_i,
   output logic        busy_o,
   output logic        cmd_complete_o,
   output logic        timeout_err_o,
   output logic [2:0]  state_o
);

   localparam int MaxCnt = (NccCycles > RspTimeout) ? NccCycles : RspTimeout;
   localparam int CntW   = $clog2(MaxCnt + 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   localparam logic [CntW-1:0] RspLast = CntW'(RspTimeout - 1);
   localparam logic [CntW-1:0] GapLast = CntW'(NccCycles - 1);

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_START        = 3'd1;
   localparam logic [2:0] ST_WAIT_TX      = 3'd2;
   localparam logic [2:0] ST_WAIT_RSP     = 3'd3;
   localparam logic [2:0] ST_WAIT_RSP_END = 3'd4;
   localparam logic [2:0] ST_GAP          = 3'd5;

   logic [2:0]      state;
   logic [CntW-1:0] cnt;
   logic            sent;
   logic [1:0]      rsp_type;

   // Request/ack handshake: a requester holds req high with stable fields; the grant
   // is a one-enabled-cycle ack pulse, after which req may drop. Auto beats host.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         sent           <= 1'b0;
         rsp_type       <= 2'b00;
         host_ack_o     <= 1'b0;
         auto_ack_o     <= 1'b0;
         start_tx_o     <= 1'b0;
         cmd_complete_o <= 1'b0;
         timeout_err_o  <= 1'b0;
         cmd_nr_o       <= '0;
         cmd_argument_o <= '0;
      end else if (clk_en_i) begin
         host_ack_o     <= 1'b0;
         auto_ack_o     <= 1'b0;
         start_tx_o     <= 1'b0;
         cmd_complete_o <= 1'b0;
         timeout_err_o  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (auto_req_i) begin
                  cmd_nr_o       <= 6'd12;
                  cmd_argument_o <= '0;
                  rsp_type       <= 2'b11;
                  auto_ack_o     <= 1'b1;
                  state          <= ST_START;
               end else if (host_req_i) begin
                  cmd_nr_o       <= host_cmd_nr_i;
                  cmd_argument_o <= host_arg_i;
                  rsp_type       <= host_rsp_type_i;
                  host_ack_o     <= 1'b1;
                  state          <= ST_START;
               end
            end
            ST_START: begin
               start_tx_o <= 1'b1;
               sent       <= 1'b0;
               state      <= ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
               // tx_done is only trusted once it has been seen low for this command
               if (!tx_done_i) begin
                  sent <= 1'b1;
               end else if (sent) begin
                  cnt <= '0;
                  if (rsp_type == 2'b00) begin
                     cmd_complete_o <= 1'b1;
                     state          <= ST_GAP;
                  end else begin
                     state <= ST_WAIT_RSP;
                  end
               end
            end
            ST_WAIT_RSP: begin
               if (rsp_start_i) begin
                  state <= ST_WAIT_RSP_END;
               end else if (cnt == RspLast) begin
                  timeout_err_o <= 1'b1;
                  cnt           <= '0;
                  state         <= ST_GAP;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            ST_WAIT_RSP_END: begin
               if (rsp_done_i) begin
                  cmd_complete_o <= 1'b1;
                  cnt            <= '0;
                  state          <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (cnt == GapLast) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CntOne;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy_o  = (state != ST_IDLE);
   assign state_o = state;

endmodule
